error_capture: RTL and testbench

- On-chip logger for ADPLL phase-error samples; replaces offline text logging of the error bus with a parametrised, triggerable capture buffer.
- Samples a signed error word on a strobe, with optional decimation and a selectable trigger.
- Stores DEPTH post-trigger samples in a BRAM-style array, then streams them out over a valid/ready port while tracking the peak |error| seen.
- Sits beside the ADPLL in the fpga_clk_i domain; the strobe is the phase-detector update pulse.

---
 rtl/error_capture_if.sv | 35 +++
 rtl/error_capture.sv | 233 +++++++++++++++++++++++
 tb/tb_error_capture.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/error_capture_if.sv
// Bus bundle for the ADPLL phase-error capture buffer: sample input,
// capture control, and the valid/ready readout stream with status.
interface error_capture_if #(
    parameter int ERR_W   = 8,
    parameter int DECIM_W = 8
) ();
    logic               enable_i;
    logic [ERR_W-1:0]   error_i;
    logic               error_valid_i;
    logic [DECIM_W-1:0] decim_i;
    logic [1:0]         trig_mode_i;
    logic [ERR_W-1:0]   trig_thresh_i;
    logic               arm_i;
    logic               abort_i;
    logic               rd_ready_i;
    logic               rd_valid_o;
    logic [ERR_W-1:0]   rd_data_o;
    logic               rd_last_o;
    logic [1:0]         state_o;
    logic [ERR_W-1:0]   max_abs_o;

    // Producer/consumer side (ADPLL control logic or a bench)
    modport master (
        output enable_i, error_i, error_valid_i, decim_i, trig_mode_i,
               trig_thresh_i, arm_i, abort_i, rd_ready_i,
        input  rd_valid_o, rd_data_o, rd_last_o, state_o, max_abs_o
    );

    // Capture block side
    modport slave (
        input  enable_i, error_i, error_valid_i, decim_i, trig_mode_i,
               trig_thresh_i, arm_i, abort_i, rd_ready_i,
        output rd_valid_o, rd_data_o, rd_last_o, state_o, max_abs_o
    );
endinterface

// File: rtl/error_capture.sv
// Triggerable capture buffer for ADPLL phase-error samples.
// Arm -> wait for trigger -> store DEPTH decimated samples -> stream them
// out oldest first over valid/ready, while tracking the peak |error|.
module error_capture #(
    parameter int ERR_W      = 8,
    parameter int DEPTH_LOG2 = 8,
    parameter int DECIM_W    = 8
) (
    input  logic          fpga_clk_i,
    input  logic          reset_i,
    error_capture_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] WR_LAST = '1;
    localparam logic [DEPTH_LOG2:0]   RD_LAST = {1'b0, {DEPTH_LOG2{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_READOUT = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // Capture configuration, frozen at arm time
    logic [DECIM_W-1:0]    decim_reg;
    logic [1:0]            mode_reg;
    logic [ERR_W-1:0]      thresh_reg;

    logic [DECIM_W-1:0]    decim_cnt_reg;
    logic                  prev_valid_reg;
    logic                  prev_sign_reg;
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    // Fetch pointer; reaching DEPTH means every sample has been fetched
    logic [DEPTH_LOG2:0]   rd_ptr_reg;
    logic [ERR_W-1:0]      max_abs_reg;
    logic                  rd_valid_reg;
    logic                  rd_last_reg;

    logic [ERR_W-1:0]      mem [DEPTH];
    logic [ERR_W-1:0]      rd_q;

    logic                  arm_go;
    logic                  strobe;
    logic                  accept;
    logic [ERR_W-1:0]      err_abs;
    logic                  err_sign;
    logic                  trig_hit;
    logic                  rd_fire;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic                  rd_load;

    assign err_sign = bus.error_i[ERR_W-1];
    // Two's-complement magnitude; the most negative value maps to 2^(ERR_W-1)
    assign err_abs  = err_sign ? (~bus.error_i + ERR_W'(1)) : bus.error_i;

    assign arm_go   = (state_reg == ST_IDLE) && bus.arm_i && !bus.abort_i;
    assign strobe   = bus.enable_i && bus.error_valid_i && !bus.abort_i &&
                      ((state_reg == ST_ARMED) || (state_reg == ST_CAPTURE));
    assign accept   = strobe && (decim_cnt_reg == '0);
    assign rd_fire  = rd_valid_reg && bus.rd_ready_i;

    // Trigger condition evaluated against the mode latched at arm time
    always_comb begin
        trig_hit = 1'b1;
        case (mode_reg)
            2'd1:    trig_hit = (err_abs >= thresh_reg);
            2'd2:    trig_hit = prev_valid_reg && (err_sign != prev_sign_reg);
            default: trig_hit = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state plus buffer write/read strobes; abort overrides everything
    always_comb begin
        state_next = state_reg;
        wr_en      = 1'b0;
        wr_addr    = wr_ptr_reg;
        rd_load    = 1'b0;
        if (bus.abort_i) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.arm_i) begin
                        state_next = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (accept && trig_hit) begin
                        wr_en      = 1'b1;
                        wr_addr    = '0;
                        state_next = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (accept) begin
                        wr_en = 1'b1;
                        if (wr_ptr_reg == WR_LAST) begin
                            state_next = ST_READOUT;
                        end
                    end
                end
                ST_READOUT: begin
                    // Fetch the next sample whenever the output slot is free
                    // or being consumed this cycle, giving one beat per cycle.
                    rd_load = !rd_ptr_reg[DEPTH_LOG2] &&
                              (!rd_valid_reg || bus.rd_ready_i);
                    if (rd_fire && rd_last_reg) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Latch capture configuration on arm
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            decim_reg  <= '0;
            mode_reg   <= '0;
            thresh_reg <= '0;
        end else if (arm_go) begin
            decim_reg  <= bus.decim_i;
            mode_reg   <= bus.trig_mode_i;
            thresh_reg <= bus.trig_thresh_i;
        end
    end

    // Decimation counter: accept when zero, then reload; else count down
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            decim_cnt_reg <= '0;
        end else if (arm_go) begin
            decim_cnt_reg <= '0;
        end else if (strobe) begin
            if (decim_cnt_reg == '0) begin
                decim_cnt_reg <= decim_reg;
            end else begin
                decim_cnt_reg <= decim_cnt_reg - DECIM_W'(1);
            end
        end
    end

    // Remember sign of the previous accepted sample for the sign-change trigger
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            prev_valid_reg <= 1'b0;
            prev_sign_reg  <= 1'b0;
        end else if (arm_go) begin
            prev_valid_reg <= 1'b0;
            prev_sign_reg  <= 1'b0;
        end else if (accept && (state_reg == ST_ARMED)) begin
            prev_valid_reg <= 1'b1;
            prev_sign_reg  <= err_sign;
        end
    end

    // Write pointer and running peak magnitude of stored samples
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_reg  <= '0;
            max_abs_reg <= '0;
        end else if (arm_go) begin
            wr_ptr_reg  <= '0;
            max_abs_reg <= '0;
        end else if (wr_en) begin
            wr_ptr_reg <= wr_addr + DEPTH_LOG2'(1);
            if (err_abs > max_abs_reg) begin
                max_abs_reg <= err_abs;
            end
        end
    end

    // Readout fetch pointer and output valid/last flags
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr_reg   <= '0;
            rd_valid_reg <= 1'b0;
            rd_last_reg  <= 1'b0;
        end else begin
            if (arm_go) begin
                rd_ptr_reg <= '0;
            end else if (rd_load) begin
                rd_ptr_reg <= rd_ptr_reg + (DEPTH_LOG2 + 1)'(1);
            end

            if (bus.abort_i || (state_reg != ST_READOUT)) begin
                rd_valid_reg <= 1'b0;
                rd_last_reg  <= 1'b0;
            end else if (rd_load) begin
                rd_valid_reg <= 1'b1;
                rd_last_reg  <= (rd_ptr_reg == RD_LAST);
            end else if (rd_fire) begin
                rd_valid_reg <= 1'b0;
                rd_last_reg  <= 1'b0;
            end
        end
    end

    // Sample buffer write port
    always_ff @(posedge fpga_clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= bus.error_i;
        end
    end

    // Sample buffer registered read port; only advances on a fetch so the
    // presented word holds while the consumer stalls
    always_ff @(posedge fpga_clk_i) begin
        if (rd_load) begin
            rd_q <= mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
        end
    end

    // Data is forced to zero when nothing is presented so reset clears it
    assign bus.rd_data_o  = rd_valid_reg ? rd_q : '0;
    assign bus.rd_valid_o = rd_valid_reg;
    assign bus.rd_last_o  = rd_last_reg;
    assign bus.state_o    = state_reg;
    assign bus.max_abs_o  = max_abs_reg;
endmodule

// File: tb/tb_error_capture.sv
// Scoreboard bench for error_capture with a 16-deep buffer.
module tb_error_capture;
    localparam int DEPTH = 16;

    logic clk;
    logic rst;

    error_capture_if #(.ERR_W(8), .DECIM_W(8)) bus ();

    error_capture #(.ERR_W(8), .DEPTH_LOG2(4), .DECIM_W(8)) dut (
        .fpga_clk_i (clk),
        .reset_i    (rst),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] sb_q[$];
    int stim_q[$];

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Arm and feed stim_q; the model decides which strobes get stored
    task automatic run_capture(input int mode, input int thresh, input int decim,
                               input bit en_gaps, output int exp_max);
        int en_cnt = 0;
        int pushed = 0;
        bit trig = 0;
        bit have_prev = 0;
        bit prev_neg = 0;
        bit acc, fire, en;
        int v;
        exp_max = 0;
        bus.decim_i       = 8'(decim);
        bus.trig_mode_i   = 2'(mode);
        bus.trig_thresh_i = 8'(thresh);
        bus.arm_i         = 1'b1;
        tick();
        bus.arm_i = 1'b0;
        check("armed_state", int'(bus.state_o), 1);
        for (int i = 0; i < stim_q.size() && pushed < DEPTH; i++) begin
            v  = stim_q[i];
            en = !(en_gaps && (i % 4 == 3));
            bus.error_i       = 8'(v);
            bus.error_valid_i = 1'b1;
            bus.enable_i      = en;
            tick();
            bus.error_valid_i = 1'b0;
            bus.enable_i      = 1'b1;
            acc = 0;
            if (en) begin
                acc = ((en_cnt % (decim + 1)) == 0);
                en_cnt++;
            end
            if (acc) begin
                if (!trig) begin
                    case (mode)
                        1:       fire = (iabs(v) >= thresh);
                        2:       fire = have_prev && ((v < 0) != prev_neg);
                        default: fire = 1;
                    endcase
                    have_prev = 1;
                    prev_neg  = (v < 0);
                    if (fire) trig = 1;
                end
                if (trig) begin
                    sb_q.push_back(8'(v));
                    if (iabs(v) > exp_max) exp_max = iabs(v);
                    pushed++;
                    if (pushed == 1) check("capture_state", int'(bus.state_o), 2);
                end
            end
        end
        check("captured", pushed, DEPTH);
        check("readout_state", int'(bus.state_o), 3);
        check("max_abs", int'(bus.max_abs_o), exp_max);
    endtask

    // Pop scoreboard on every handshake; optional random back-pressure
    task automatic drain(input bit rnd, input int exp_max);
        int cyc = 0, beats = 0, stall = 0, first = -1, last_cyc = 0;
        bit done = 0, hold = 0;
        logic [7:0] held = '0;
        logic [7:0] exp;
        while (!done && cyc < 400) begin
            if (rnd) begin
                if (beats == 2 && stall < 5) begin
                    bus.rd_ready_i = 1'b0;
                    stall++;
                end else begin
                    bus.rd_ready_i = 1'($urandom_range(0, 1));
                end
            end else begin
                bus.rd_ready_i = 1'b1;
            end
            @(negedge clk);
            if (hold) begin
                check("hold_valid", int'(bus.rd_valid_o), 1);
                check("hold_data", int'(bus.rd_data_o), int'(held));
            end
            hold = 0;
            if (bus.rd_valid_o) begin
                if (first < 0) first = cyc;
                if (bus.rd_ready_i) begin
                    if (sb_q.size() == 0) begin
                        check("sb_underflow", 1, 0);
                        exp = '0;
                    end else begin
                        exp = sb_q.pop_front();
                    end
                    check("rd_data", int'(bus.rd_data_o), int'(exp));
                    check("rd_last", int'(bus.rd_last_o), (sb_q.size() == 0) ? 1 : 0);
                    $display("[TB] beat %0d data %0d last %0d", beats, bus.rd_data_o, bus.rd_last_o);
                    beats++;
                    if (bus.rd_last_o) begin
                        done = 1;
                        last_cyc = cyc;
                    end
                end else begin
                    hold = 1;
                    held = bus.rd_data_o;
                end
            end
            tick();
            cyc++;
        end
        bus.rd_ready_i = 1'b0;
        check("drain_done", int'(done), 1);
        check("beats", beats, DEPTH);
        check("sb_empty", sb_q.size(), 0);
        check("valid_after_last", int'(bus.rd_valid_o), 0);
        check("idle_after_last", int'(bus.state_o), 0);
        check("max_hold", int'(bus.max_abs_o), exp_max);
        if (!rnd) check("throughput", last_cyc - first + 1, DEPTH);
        sb_q.delete();
    endtask

    initial begin
        int mx;
        rst = 1'b1;
        bus.enable_i = 1'b1;   bus.error_i = '0;     bus.error_valid_i = 1'b0;
        bus.decim_i = '0;      bus.trig_mode_i = '0; bus.trig_thresh_i = '0;
        bus.arm_i = 1'b0;      bus.abort_i = 1'b0;   bus.rd_ready_i = 1'b0;
        tick();
        tick();
        check("rst_state", int'(bus.state_o), 0);
        check("rst_valid", int'(bus.rd_valid_o), 0);
        check("rst_last", int'(bus.rd_last_o), 0);
        check("rst_data", int'(bus.rd_data_o), 0);
        check("rst_max", int'(bus.max_abs_o), 0);
        rst = 1'b0;
        tick();

        // Immediate trigger, ramp -8..7, full-rate readout
        stim_q.delete();
        for (int i = -8; i < 8; i++) stim_q.push_back(i);
        run_capture(0, 0, 0, 0, mx);
        check("ramp_max", int'(bus.max_abs_o), 8);
        drain(0, mx);

        // Magnitude threshold 20
        stim_q = '{5, 10, -19, -20, 30};
        for (int i = 0; i < 15; i++) stim_q.push_back(i * 3 - 15);
        run_capture(1, 20, 0, 0, mx);
        drain(0, mx);

        // Sign change, positive then negative
        stim_q = '{3, 4, -1};
        for (int i = 0; i < 15; i++) stim_q.push_back(i - 6);
        run_capture(2, 0, 0, 0, mx);
        drain(0, mx);

        // Sign change where the very first sample is negative
        stim_q = '{-5, 6};
        for (int i = 0; i < 15; i++) stim_q.push_back(20 - i * 2);
        run_capture(2, 0, 0, 0, mx);
        drain(0, mx);

        // Decimate by 3 with random back-pressure
        stim_q.delete();
        for (int i = 0; i < 48; i++) stim_q.push_back(i);
        run_capture(0, 0, 2, 0, mx);
        drain(1, mx);

        // Enable gaps and the most negative sample
        stim_q = '{-128};
        for (int i = 0; i < 24; i++) stim_q.push_back(i * 9 - 100);
        run_capture(0, 0, 0, 1, mx);
        check("neg_full_max", int'(bus.max_abs_o), 128);
        drain(1, mx);

        // Abort together with arm during capture
        bus.trig_mode_i = 2'd0;
        bus.decim_i     = '0;
        bus.arm_i       = 1'b1;
        tick();
        bus.arm_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.error_i = 8'(i);
            bus.error_valid_i = 1'b1;
            tick();
        end
        bus.error_valid_i = 1'b0;
        check("pre_abort_state", int'(bus.state_o), 2);
        bus.abort_i = 1'b1;
        bus.arm_i   = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        bus.arm_i   = 1'b0;
        check("abort_state", int'(bus.state_o), 0);
        check("abort_valid", int'(bus.rd_valid_o), 0);
        tick();
        check("abort_stays_idle", int'(bus.state_o), 0);

        // Asynchronous reset while a readout word is presented
        stim_q.delete();
        for (int i = 0; i < 16; i++) stim_q.push_back(i * 5 - 40);
        run_capture(0, 0, 0, 0, mx);
        bus.rd_ready_i = 1'b0;
        tick();
        tick();
        check("valid_before_rst", int'(bus.rd_valid_o), 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", int'(bus.rd_valid_o), 0);
        check("arst_state", int'(bus.state_o), 0);
        check("arst_data", int'(bus.rd_data_o), 0);
        check("arst_max", int'(bus.max_abs_o), 0);
        sb_q.delete();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_state", int'(bus.state_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
